// File: rtl/rtos_sched_ctrl.sv
// Scheduler controller: round-robin arbitration of ready-list updates onto the priority selector,
// preemption/block/time-slice evaluation and the context-switch handshake to the CPU.
module rtos_sched_ctrl #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned PRIORITY_WIDTH = 6,
    parameter int unsigned SLICE_TICKS    = 10
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              sched_enable_in,
    input  logic [N_REQ-1:0]                  req_valid_in,
    input  logic [N_REQ-1:0]                  req_op_in,
    input  logic [N_REQ*PRIORITY_WIDTH-1:0]   req_priority_in,
    output logic [N_REQ-1:0]                  req_ready_out,
    output logic                              sel_add_out,
    output logic                              sel_rem_out,
    output logic [PRIORITY_WIDTH-1:0]         sel_priority_out,
    input  logic [PRIORITY_WIDTH-1:0]         sel_hpriority_in,
    input  logic                              tick_in,
    output logic                              cs_req_out,
    output logic [PRIORITY_WIDTH-1:0]         cs_priority_out,
    output logic [1:0]                        cs_reason_out,
    input  logic                              cs_ack_in,
    output logic [PRIORITY_WIDTH-1:0]         run_priority_out
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = (SLICE_TICKS > 1) ? $clog2(SLICE_TICKS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'((SLICE_TICKS == 0) ? 0 : SLICE_TICKS - 1);
    localparam logic [PtrW-1:0] LastCh = PtrW'(N_REQ - 1);
    localparam logic SliceOn = (SLICE_TICKS != 0);

    typedef enum logic [2:0] {StIdle, StIssue, StSettle, StCompare, StSwitch} state_e;

    state_e                    state_q, state_d;
    logic [PtrW-1:0]           ptr_q;
    logic [PtrW-1:0]           gnt_q;
    logic                      op_q;
    logic                      op_vld_q;
    logic [PRIORITY_WIDTH-1:0] prio_q;
    logic [PRIORITY_WIDTH-1:0] run_q;
    logic [PRIORITY_WIDTH-1:0] cs_prio_q;
    logic [1:0]                cs_reason_q;
    logic [CntW-1:0]           slice_cnt_q;
    logic                      slice_pend_q;

    logic                      any_req;
    logic [PtrW-1:0]           win;
    logic [PtrW:0]             idx;
    logic                      do_preempt, do_block, do_slice, do_switch;
    logic [1:0]                reason;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + (PtrW+1)'(k);
            if (idx >= (PtrW+1)'(N_REQ)) begin
                idx = idx - (PtrW+1)'(N_REQ);
            end
            if (!any_req && req_valid_in[idx[PtrW-1:0]]) begin
                any_req = 1'b1;
                win     = idx[PtrW-1:0];
            end
        end
    end

    always_comb begin
        do_preempt = sel_hpriority_in > run_q;
        do_block   = op_vld_q && !op_q && (prio_q == run_q) && (sel_hpriority_in < run_q);
        do_slice   = SliceOn && slice_pend_q && (sel_hpriority_in == run_q);
        do_switch  = do_preempt || do_block || do_slice;
        if (do_preempt) begin
            reason = 2'b01;
        end else if (do_block) begin
            reason = 2'b10;
        end else begin
            reason = 2'b11;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (sched_enable_in && any_req) begin
                    state_d = StIssue;
                end else if (sched_enable_in && slice_pend_q) begin
                    state_d = StCompare;
                end
            end
            StIssue:   state_d = StSettle;
            StSettle:  state_d = StCompare;
            StCompare: state_d = do_switch ? StSwitch : StIdle;
            StSwitch:  state_d = cs_ack_in ? StIdle : StSwitch;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_out    = '0;
        sel_add_out      = 1'b0;
        sel_rem_out      = 1'b0;
        sel_priority_out = '0;
        cs_req_out       = 1'b0;
        case (state_q)
            StIssue: begin
                req_ready_out    = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_q;
                sel_add_out      = op_q;
                sel_rem_out      = !op_q;
                sel_priority_out = prio_q;
            end
            StSwitch: cs_req_out = 1'b1;
            default: ;
        endcase
        cs_priority_out  = cs_prio_q;
        cs_reason_out    = cs_reason_q;
        run_priority_out = run_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ptr_q       <= '0;
            gnt_q       <= '0;
            op_q        <= 1'b0;
            op_vld_q    <= 1'b0;
            prio_q      <= '0;
            run_q       <= '0;
            cs_prio_q   <= '0;
            cs_reason_q <= '0;
        end else begin
            if (state_q == StIdle && sched_enable_in) begin
                if (any_req) begin
                    gnt_q    <= win;
                    op_q     <= req_op_in[win];
                    prio_q   <= req_priority_in[win*PRIORITY_WIDTH +: PRIORITY_WIDTH];
                    op_vld_q <= 1'b1;
                end else if (slice_pend_q) begin
                    // Slice-only evaluation: no add/remove to consider for blocking.
                    op_vld_q <= 1'b0;
                end
            end
            if (state_q == StIssue) begin
                ptr_q <= (gnt_q == LastCh) ? '0 : gnt_q + 1'b1;
            end
            if (state_q == StCompare && do_switch) begin
                cs_prio_q   <= sel_hpriority_in;
                cs_reason_q <= reason;
            end
            if (state_q == StSwitch && cs_ack_in) begin
                run_q <= cs_prio_q;
            end
        end
    end

    // Ticks arriving while a switch is outstanding are dropped.
    always_ff @(posedge aclk) begin
        if (areset) begin
            slice_cnt_q  <= '0;
            slice_pend_q <= 1'b0;
        end else if (state_q == StSwitch) begin
            if (cs_ack_in) begin
                slice_cnt_q  <= '0;
                slice_pend_q <= 1'b0;
            end
        end else if (tick_in && SliceOn) begin
            if (slice_cnt_q == CntMax) begin
                slice_cnt_q  <= '0;
                slice_pend_q <= 1'b1;
            end else begin
                slice_cnt_q <= slice_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtos_sched_ctrl.sv
// Bench for rtos_sched_ctrl: directed handshake scenarios plus randomized traffic checked
// against a cycle-timeline reference model and a behavioural priority-selector bitmap.
module tb_rtos_sched_ctrl;

    localparam int N  = 4;
    localparam int PW = 6;
    localparam int ST = 3;

    logic          aclk = 1'b0;
    logic          areset;
    logic          sched_enable_in;
    logic [N-1:0]  req_valid_in;
    logic [N-1:0]  req_op_in;
    logic [N*PW-1:0] req_priority_in;
    logic [N-1:0]  req_ready_out;
    logic          sel_add_out, sel_rem_out;
    logic [PW-1:0] sel_priority_out;
    logic [PW-1:0] sel_hpriority_in;
    logic          tick_in;
    logic          cs_req_out;
    logic [PW-1:0] cs_priority_out;
    logic [1:0]    cs_reason_out;
    logic          cs_ack_in;
    logic [PW-1:0] run_priority_out;

    rtos_sched_ctrl #(
        .N_REQ          (N),
        .PRIORITY_WIDTH (PW),
        .SLICE_TICKS    (ST)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .sched_enable_in  (sched_enable_in),
        .req_valid_in     (req_valid_in),
        .req_op_in        (req_op_in),
        .req_priority_in  (req_priority_in),
        .req_ready_out    (req_ready_out),
        .sel_add_out      (sel_add_out),
        .sel_rem_out      (sel_rem_out),
        .sel_priority_out (sel_priority_out),
        .sel_hpriority_in (sel_hpriority_in),
        .tick_in          (tick_in),
        .cs_req_out       (cs_req_out),
        .cs_priority_out  (cs_priority_out),
        .cs_reason_out    (cs_reason_out),
        .cs_ack_in        (cs_ack_in),
        .run_priority_out (run_priority_out)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural priority selector: a ready bitmap, priority 0 always present.
    logic [63:0] sel_map;
    always @(posedge aclk) begin
        if (areset) begin
            sel_map <= 64'h1;
        end else begin
            if (sel_add_out) sel_map[sel_priority_out] <= 1'b1;
            if (sel_rem_out && sel_priority_out != 0) sel_map[sel_priority_out] <= 1'b0;
        end
    end
    always_comb begin
        sel_hpriority_in = '0;
        for (int i = 0; i < 64; i++) if (sel_map[i]) sel_hpriority_in = PW'(i);
    end

    // Reference model: tracks each accepted transaction by cycles elapsed since acceptance.
    bit m_on = 0;
    int m_ptr, m_run, m_ticks, m_age, m_ch, m_prio, m_sw_prio, m_sw_reason;
    bit m_pend, m_op, m_has_op, m_sw;
    logic [N-1:0] rdy_seen;

    initial begin
        forever begin
            @(negedge aclk);
            rdy_seen = req_ready_out;
            if (m_on) begin
                logic [N-1:0] e_rdy;
                int h;
                e_rdy = '0;
                if (m_age == 1) e_rdy[m_ch] = 1'b1;
                check_eq("ready", req_ready_out, e_rdy);
                check_eq("sel_add", sel_add_out, (m_age == 1) && m_op);
                check_eq("sel_rem", sel_rem_out, (m_age == 1) && !m_op);
                check_eq("sel_prio", sel_priority_out, (m_age == 1) ? m_prio : 0);
                check_eq("cs_req", cs_req_out, m_sw);
                check_eq("run_prio", run_priority_out, m_run);
                if (m_sw) begin
                    check_eq("cs_prio", cs_priority_out, m_sw_prio);
                    check_eq("cs_reason", cs_reason_out, m_sw_reason);
                end
                h = int'(sel_hpriority_in);
                if (m_sw) begin
                    if (cs_ack_in) begin
                        m_run = m_sw_prio; m_sw = 0; m_ticks = 0; m_pend = 0;
                    end
                end else begin
                    if (m_age == 3) begin
                        m_age = -1;
                        if (h > m_run) begin
                            m_sw = 1; m_sw_reason = 1;
                        end else if (m_has_op && !m_op && m_prio == m_run && h < m_run) begin
                            m_sw = 1; m_sw_reason = 2;
                        end else if (m_pend && h == m_run) begin
                            m_sw = 1; m_sw_reason = 3;
                        end
                        m_sw_prio = h;
                    end else if (m_age == 1) begin
                        m_ptr = (m_ch + 1) % N;
                        m_age = 2;
                    end else if (m_age == 2) begin
                        m_age = 3;
                    end else if (sched_enable_in) begin
                        if (req_valid_in != 0) begin
                            for (int k = N - 1; k >= 0; k--)
                                if (req_valid_in[(m_ptr + k) % N]) m_ch = (m_ptr + k) % N;
                            m_op = req_op_in[m_ch];
                            m_prio = int'(req_priority_in[m_ch*PW +: PW]);
                            m_has_op = 1; m_age = 1;
                        end else if (m_pend) begin
                            m_has_op = 0; m_age = 3;
                        end
                    end
                    if (tick_in) begin
                        m_ticks++;
                        if (m_ticks == ST) begin m_ticks = 0; m_pend = 1; end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input int ch, input bit op, input int prio);
        req_valid_in[ch] = 1'b1;
        req_op_in[ch] = op;
        req_priority_in[ch*PW +: PW] = PW'(prio);
    endtask

    task automatic do_reset();
        req_valid_in = '0; req_op_in = '0; req_priority_in = '0;
        tick_in = 0; cs_ack_in = 0; sched_enable_in = 1;
        areset = 1;
        repeat (2) step();
        areset = 0;
    endtask

    task automatic ack_switch();
        cs_ack_in = 1;
        step();
        cs_ack_in = 0;
    endtask

    initial begin
        int gap, seen;
        logic [N-1:0] exp_oh;
        do_reset();
        @(negedge aclk);
        check_eq("rst_ready", req_ready_out, 0);
        check_eq("rst_strobes", {sel_add_out, sel_rem_out, sel_priority_out}, 0);
        check_eq("rst_cs", {cs_req_out, cs_priority_out, cs_reason_out}, 0);
        check_eq("rst_run", run_priority_out, 0);

        // Add 5 on ch0 from run 0: preempt.
        step(); set_req(0, 1, 5);
        step(); @(negedge aclk);
        check_eq("a_ready", req_ready_out, 4'b0001);
        check_eq("a_add", {sel_add_out, sel_rem_out, sel_priority_out}, {2'b10, 6'd5});
        req_valid_in[0] = 0;
        step(); step(); @(negedge aclk);
        check_eq("a_cs_early", cs_req_out, 0);
        step(); @(negedge aclk);
        check_eq("a_cs", {cs_req_out, cs_priority_out, cs_reason_out}, {1'b1, 6'd5, 2'b01});
        ack_switch(); @(negedge aclk);
        check_eq("a_run", {cs_req_out, run_priority_out}, {1'b0, 6'd5});

        // Add 3 on ch1 (no switch), then remove 5 on ch2: block.
        step(); set_req(1, 1, 3);
        step(); @(negedge aclk);
        check_eq("b_ready", req_ready_out, 4'b0010);
        req_valid_in[1] = 0;
        step(); step(); step(); @(negedge aclk);
        check_eq("b_no_cs", cs_req_out, 0);
        set_req(2, 0, 5);
        step(); @(negedge aclk);
        check_eq("b_rem", {req_ready_out, sel_add_out, sel_rem_out, sel_priority_out},
                 {4'b0100, 2'b01, 6'd5});
        req_valid_in[2] = 0;
        step(); step(); step(); @(negedge aclk);
        check_eq("b_cs", {cs_req_out, cs_priority_out, cs_reason_out}, {1'b1, 6'd3, 2'b10});
        ack_switch(); @(negedge aclk);
        check_eq("b_run", run_priority_out, 3);

        // All four valid with pointer at 3: grants 3,0,1,2 four cycles apart.
        step();
        for (int c = 0; c < N; c++) set_req(c, 1, 1);
        for (int k = 0; k < N; k++) begin
            gap = 0; seen = 0;
            while (!seen && gap < 10) begin
                @(negedge aclk);
                if (req_ready_out != 0) seen = 1; else begin gap++; step(); end
            end
            exp_oh = '0; exp_oh[(3 + k) % N] = 1'b1;
            check_eq("rr_grant", req_ready_out, exp_oh);
            if (k > 0) check_eq("rr_gap", gap, 3);
            req_valid_in[(3 + k) % N] = 0;
            step();
        end

        // Randomized traffic against the reference model.
        do_reset();
        m_ptr = 0; m_run = 0; m_ticks = 0; m_pend = 0; m_age = -1; m_sw = 0; m_has_op = 0;
        m_on = 1;
        repeat (4000) begin
            step();
            req_valid_in = req_valid_in & ~rdy_seen;
            for (int c = 0; c < N; c++) begin
                if (!req_valid_in[c] && $urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 2) != 0) set_req(c, 1, $urandom_range(0, 20));
                    else if ($urandom_range(0, 1) == 0) set_req(c, 0, m_run);
                    else set_req(c, 0, $urandom_range(0, 20));
                end
            end
            tick_in = ($urandom_range(0, 3) == 0);
            sched_enable_in = ($urandom_range(0, 15) != 0);
            cs_ack_in = cs_req_out && ($urandom_range(0, 2) == 0);
        end
        step();
        m_on = 0;

        // Held request with no ack, then reset mid-switch.
        do_reset();
        set_req(0, 1, 40);
        step(); req_valid_in[0] = 0;
        step(); step(); step(); set_req(1, 1, 50);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check_eq("hold_cs", {cs_req_out, cs_priority_out, cs_reason_out},
                     {1'b1, 6'd40, 2'b01});
            check_eq("hold_ready", req_ready_out, 0);
            step();
        end
        areset = 1;
        step();
        areset = 0;
        @(negedge aclk);
        check_eq("mid_rst_cs", {cs_req_out, run_priority_out}, 0);
        step(); @(negedge aclk);
        check_eq("mid_rst_idle", req_ready_out, 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
